fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the execute stage of the RV32I core. It generates sequential PCs, issues word reads to instruction memory over a req/gnt/rvalid interface, and presents {pc_o, inst_o, inst_v_o} for execute to latch. It accepts the branch redirect (pc_v_x, pc_x) from execute, squashes wrong-path instructions and restarts fetch at the target. Execute never stalls, so every asserted inst_v_o is consumed in that cycle.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests (power of 2, >=1)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
imem_req_o  input/output: output  1  fetch request valid
imem_addr_o  output  32  fetch byte address, bits [1:0] always 0
imem_gnt_i  input  1  memory accepts request this cycle (req & gnt = handshake)
imem_rvalid_i  input  1  response valid; responses return in request order, latency >=1
imem_rdata_i  input  32  instruction word
pc_v_x  input  1  redirect taken (from execute)
pc_x  input  32  redirect target
pc_o  output  32  PC of presented instruction
inst_v_o  output  1  instruction valid
inst_o  output  32  instruction word
misalign_o  output  1  sticky: redirect target not word-aligned; fetch halted

Behaviour:
- Reset values: fetch_pc=RESET_PC, epoch=0, outstanding=0, inst_v_o=0, pc_o=0, inst_o=0, misalign_o=0, tag FIFO empty; imem_req_o=0 during reset cycle.
- Request: imem_req_o = !reset & !misalign_o & (outstanding < MAX_OUTSTANDING). imem_addr_o = pc_v_x ? pc_x : fetch_pc (redirect target issued in the redirect cycle, no bubble).
- On req & gnt: push {addr, epoch_next} into tag FIFO; fetch_pc <= addr + 4 (wraps mod 2^32). Without gnt, req and addr held (unless redirect changes addr).
- outstanding = tag FIFO occupancy; push and pop in same cycle leaves it unchanged. Never exceeds MAX_OUTSTANDING.
- Response: imem_rvalid_i pops FIFO head. If head epoch == current epoch and no redirect this cycle: next cycle inst_v_o=1, inst_o=imem_rdata_i, pc_o=head addr. Otherwise dropped (inst_v_o=0 next cycle).
- Latency: request granted in cycle t with 1-cycle memory -> rvalid t+1 -> inst_v_o t+2. Steady-state throughput 1 instr/cycle with MAX_OUTSTANDING>=2.
- Redirect (pc_v_x=1 in cycle r): inst_v_o forced 0 combinationally in cycle r (wrong-path instruction behind the branch must not be latched by execute); epoch toggles at r (epoch_next = ~epoch used for any push in r); all older in-flight responses dropped; fetch_pc <= pc_x+4 if target granted in r, else pc_x.
- Misaligned target (pc_x[1:0]!=0 with pc_v_x): no request for it, misalign_o<=1, inst_v_o=0 thereafter, in-flight responses drained and dropped. Only reset clears it.
- rvalid with empty FIFO (e.g. first cycles after reset mid-operation): ignored, no output; bench flags as protocol error except in the 2 cycles after reset.
- Reset mid-operation: all state returns to reset values in the next cycle regardless of pending requests.

Decomposition:
- Shared instruction package: RESET_PC default constant, fetch tag struct {addr[31:0], epoch}.
- Sub-module fetch_tag_fifo: MAX_OUTSTANDING-deep synchronous FIFO of tags, push/pop/full/empty, same-cycle push+pop allowed when full.

Test Plan:
- Reset release, memory gnt=1, latency 1: addrs 0,4,8,... issued each cycle; inst_v_o from cycle 2 with pc_o 0,4,8 and matching inst_o, no gaps.
- gnt low for 3 cycles at addr 0x10: imem_addr_o held at 0x10, no duplicate push, outputs resume in order 0x10,0x14.
- pc_v_x=1, pc_x=0x100 while 2 requests in flight: inst_v_o=0 in redirect cycle, both stale responses dropped, next valid output pc_o=0x100 then 0x104.
- Back-to-back redirects 0x200 then 0x300 on consecutive cycles: 0x200 response dropped, first valid pc_o=0x300.
- pc_x=0x102 redirect: misalign_o=1 next cycle, imem_req_o stays 0, inst_v_o stays 0 until reset.
- Reset asserted with 2 outstanding, memory answers both after reset: no inst_v_o, first output pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
// A fetch tag records the address and epoch of one granted imem request.
package fetch_unit_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic        epoch;
  } fetch_tag_t;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_tag_fifo.sv
// In-order FIFO of tags for imem requests that are granted but not yet answered.
// Push and pop in the same cycle are accepted even when the FIFO is full.
module fetch_tag_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  fetch_tag_t push_tag,
  input  logic       pop,
  output fetch_tag_t head_tag,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  fetch_tag_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            push_ok;
  logic            pop_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FullCnt);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign head_tag = mem_q[rd_ptr_q];

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential word reads to imem and presents
// {pc, inst} to execute, squashing wrong-path responses on a branch redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DefaultResetPc,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        pc_v_x,
  input  logic [31:0] pc_x,
  output logic [31:0] pc_o,
  output logic        inst_v_o,
  output logic [31:0] inst_o,
  output logic        misalign_o
);

  logic [31:0] fetch_pc_q;
  logic        epoch_q;
  logic        misalign_q;
  logic        inst_v_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  logic        epoch_next;
  logic        redirect_bad;
  logic [31:0] req_addr;
  logic        handshake;
  logic        resp_keep;
  logic        tag_full;
  logic        tag_empty;
  fetch_tag_t  push_tag;
  fetch_tag_t  head_tag;

  assign redirect_bad = pc_v_x & (pc_x[1:0] != 2'b00);
  assign epoch_next   = epoch_q ^ pc_v_x;

  // The redirect target goes out in the redirect cycle itself, so no bubble.
  assign req_addr    = pc_v_x ? pc_x : fetch_pc_q;
  assign imem_addr_o = {req_addr[31:2], 2'b00};
  assign imem_req_o  = ~reset & ~misalign_q & ~tag_full & ~redirect_bad;
  assign handshake   = imem_req_o & imem_gnt_i;

  assign push_tag = '{addr: req_addr, epoch: epoch_next};

  // Responses tagged with an old epoch, or arriving with a redirect, are wrong-path.
  assign resp_keep = imem_rvalid_i & ~tag_empty & (head_tag.epoch == epoch_q) &
                     ~pc_v_x & ~misalign_q;

  fetch_tag_fifo #(
    .Depth (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (handshake),
    .push_tag (push_tag),
    .pop      (imem_rvalid_i),
    .head_tag (head_tag),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      epoch_q    <= 1'b0;
      misalign_q <= 1'b0;
      inst_v_q   <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
    end else begin
      if (handshake) begin
        fetch_pc_q <= next_word(req_addr);
      end else if (pc_v_x) begin
        fetch_pc_q <= pc_x;
      end
      epoch_q <= epoch_next;
      if (redirect_bad) begin
        misalign_q <= 1'b1;
      end
      inst_v_q <= resp_keep;
      if (resp_keep) begin
        pc_q   <= head_tag.addr;
        inst_q <= imem_rdata_i;
      end
    end
  end

  // Execute latches inst_v_o in the redirect cycle, so the wrong-path slot is masked here.
  assign inst_v_o   = inst_v_q & ~pc_v_x;
  assign pc_o       = pc_q;
  assign inst_o     = inst_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model and a transaction-level
// reference model compared on every negative clock edge.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RstPc = 32'h0000_0000;
  localparam int          MaxO  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        pc_v_x = 1'b0;
  logic [31:0] pc_x = 32'h0;
  logic [31:0] pc_o;
  logic        inst_v_o;
  logic [31:0] inst_o;
  logic        misalign_o;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC        (RstPc),
    .MAX_OUTSTANDING (MaxO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_v_x        (pc_v_x),
    .pc_x          (pc_x),
    .pc_o          (pc_o),
    .inst_v_o      (inst_v_o),
    .inst_o        (inst_o),
    .misalign_o    (misalign_o)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: answers granted requests in order, one per cycle, latency 1, unless held.
  logic [31:0] mq[$];
  bit          hold = 1'b0;

  task automatic step();
    bit          hs;
    logic [31:0] ha;
    #2;
    hs = imem_req_o && imem_gnt_i;
    ha = imem_addr_o;
    @(posedge clk);
    #1;
    if (hs) mq.push_back(ha);
    if (!hold && mq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(mq.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
  endtask

  // Reference model: queue of in-flight {addr, epoch}, epoch flip per redirect.
  typedef struct {
    logic [31:0] addr;
    logic        ep;
  } mtag_t;
  typedef struct {
    int          age;
    logic [31:0] pc;
    logic [31:0] inst;
  } log_t;

  mtag_t       m_q[$];
  logic [31:0] m_fpc = RstPc;
  logic        m_ep = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_v = 1'b0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_inst = 32'h0;
  int          age = 0;
  log_t        lg[$];

  always @(negedge clk) begin
    logic        exp_req;
    logic        exp_v;
    logic        bad;
    logic        ep_n;
    logic [31:0] exp_addr;
    mtag_t       h;
    bad     = pc_v_x && (pc_x[1:0] != 2'b00);
    exp_req = !reset && !m_mis && (m_q.size() < MaxO) && !bad;
    check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
    if (reset) begin
      m_q.delete();
      m_fpc  = RstPc;
      m_ep   = 1'b0;
      m_mis  = 1'b0;
      m_v    = 1'b0;
      m_pc   = 32'h0;
      m_inst = 32'h0;
      age    = 0;
    end else begin
      exp_addr = pc_v_x ? pc_x : m_fpc;
      exp_v    = m_v && !pc_v_x;
      if (exp_req) check("addr", imem_addr_o, exp_addr);
      check("inst_v", {31'b0, inst_v_o}, {31'b0, exp_v});
      check("misalign", {31'b0, misalign_o}, {31'b0, m_mis});
      if (exp_v) begin
        check("pc", pc_o, m_pc);
        check("inst", inst_o, m_inst);
      end
      if (inst_v_o) lg.push_back('{age, pc_o, inst_o});
      ep_n = m_ep ^ pc_v_x;
      m_v  = 1'b0;
      if (imem_rvalid_i) begin
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          if (h.ep == m_ep && !pc_v_x && !m_mis) begin
            m_v    = 1'b1;
            m_pc   = h.addr;
            m_inst = imem_rdata_i;
          end
        end else if (age >= 2) begin
          tests++;
          fails++;
          $display("FAIL protocol: rvalid with nothing outstanding at age %0d", age);
        end
      end
      if (exp_req && imem_gnt_i) begin
        m_q.push_back('{exp_addr, ep_n});
        m_fpc = exp_addr + 32'd4;
      end else if (pc_v_x) begin
        m_fpc = pc_x;
      end
      m_ep = ep_n;
      if (bad) m_mis = 1'b1;
      age++;
    end
  end

  task automatic do_reset(input bit g, input bit hld);
    reset      = 1'b1;
    pc_v_x     = 1'b0;
    imem_gnt_i = 1'b0;
    hold       = 1'b0;
    repeat (4) step();
    check("rst_inst_v", {31'b0, inst_v_o}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_misalign", {31'b0, misalign_o}, 32'd0);
    check("rst_req", {31'b0, imem_req_o}, 32'd0);
    reset      = 1'b0;
    imem_gnt_i = g;
    hold       = hld;
    lg.delete();
  endtask

  task automatic expect_log(input string nm, input int n, input logic [0:5][31:0] p,
                            input logic [0:5][7:0] a);
    check({nm, "_len"}, {31'b0, (lg.size() >= n)}, 32'd1);
    for (int i = 0; i < n && i < lg.size(); i++) begin
      check($sformatf("%s_pc%0d", nm, i), lg[i].pc, p[i]);
      check($sformatf("%s_age%0d", nm, i), lg[i].age, {24'b0, a[i]});
      check($sformatf("%s_inst%0d", nm, i), lg[i].inst, inst_of(p[i]));
    end
  endtask

  initial begin
    // Streaming after reset with an always-granting memory.
    do_reset(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s1_addr", imem_addr_o, 32'(4 * i));
      step();
    end
    repeat (4) step();
    expect_log("s1", 6, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14},
               '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});

    // Grant withheld for three cycles at 0x10.
    do_reset(1'b1, 1'b0);
    repeat (4) step();
    imem_gnt_i = 1'b0;
    repeat (3) begin
      #1;
      check("s2_hold_addr", imem_addr_o, 32'h10);
      check("s2_hold_req", {31'b0, imem_req_o}, 32'd1);
      step();
    end
    imem_gnt_i = 1'b1;
    repeat (8) step();
    expect_log("s2", 6, '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14},
               '{8'd2, 8'd3, 8'd4, 8'd5, 8'd9, 8'd10});

    // Redirect to 0x100 with two requests in flight.
    do_reset(1'b1, 1'b1);
    step();
    step();
    pc_v_x = 1'b1;
    pc_x   = 32'h100;
    hold   = 1'b0;
    #1;
    check("s3_redir_v", {31'b0, inst_v_o}, 32'd0);
    step();
    pc_v_x = 1'b0;
    repeat (8) step();
    expect_log("s3", 3, '{32'h100, 32'h104, 32'h108, 32'h0, 32'h0, 32'h0},
               '{8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0});

    // Back-to-back redirects; the first masks a valid instruction.
    do_reset(1'b1, 1'b0);
    repeat (4) step();
    pc_v_x = 1'b1;
    pc_x   = 32'h200;
    #1;
    check("s4_masked_v", {31'b0, inst_v_o}, 32'd0);
    check("s4_redir_addr", imem_addr_o, 32'h200);
    step();
    pc_x = 32'h300;
    step();
    pc_v_x = 1'b0;
    repeat (6) step();
    expect_log("s4", 4, '{32'h0, 32'h4, 32'h300, 32'h304, 32'h0, 32'h0},
               '{8'd2, 8'd3, 8'd7, 8'd8, 8'd0, 8'd0});

    // Misaligned redirect halts fetch until reset.
    do_reset(1'b1, 1'b0);
    repeat (3) step();
    pc_v_x = 1'b1;
    pc_x   = 32'h102;
    #1;
    check("s5_req_in_redir", {31'b0, imem_req_o}, 32'd0);
    step();
    pc_v_x = 1'b0;
    #1;
    check("s5_misalign", {31'b0, misalign_o}, 32'd1);
    repeat (6) begin
      check("s5_req_off", {31'b0, imem_req_o}, 32'd0);
      check("s5_v_off", {31'b0, inst_v_o}, 32'd0);
      step();
    end
    check("s5_log_len", 32'(lg.size()), 32'd1);

    // Reset with two outstanding; stale answers arrive just after release.
    do_reset(1'b1, 1'b1);
    step();
    step();
    reset      = 1'b1;
    hold       = 1'b0;
    imem_gnt_i = 1'b0;
    step();
    reset = 1'b0;
    lg.delete();
    step();
    imem_gnt_i = 1'b1;
    repeat (6) step();
    expect_log("s6", 2, '{32'h0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0},
               '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
